// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state and owner encodings for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rtl/dmem_arbiter_rr_pick2.sv - 2-way requester picker; DMEM_ARB_PRIORITY_EN selects fixed CPU priority
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick,
    output logic any
);

    assign any = req0 | req1;

`ifdef DMEM_ARB_PRIORITY_EN
    logic unused_last;
    assign unused_last = last;
    assign pick        = req0 ? OWN_CPU : OWN_DBG;
`else
    // On contention the requester not served most recently goes first
    always_comb begin
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = OWN_DBG;
        end else begin
            pick = OWN_CPU;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter and sequencer for the single-port data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int addrW = 16,
    parameter int dataW = 32
) (
    input  logic             sysCLK,
    input  logic             pRST,
    input  logic             cpuReq,
    input  logic             cpuWe,
    input  logic [addrW-1:0] cpuAddr,
    input  logic [dataW-1:0] cpuWData,
    output logic             cpuGnt,
    output logic [dataW-1:0] cpuRData,
    output logic             cpuValid,
    output logic             cpuStall,
    input  logic             dbgReq,
    input  logic             dbgWe,
    input  logic [addrW-1:0] dbgAddr,
    input  logic [dataW-1:0] dbgWData,
    output logic             dbgGnt,
    output logic [dataW-1:0] dbgRData,
    output logic             dbgValid,
    output logic [addrW-1:0] memAddr,
    output logic [dataW-1:0] memWData,
    output logic             memRW,
    input  logic [dataW-1:0] memRData
);

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             we_q, we_d;
    logic [addrW-1:0] addr_q, addr_d;
    logic [dataW-1:0] wdata_q, wdata_d;
    logic [dataW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [dataW-1:0] dbg_rdata_q, dbg_rdata_d;

    logic pick, any_req, pick_last, take;

    // In RESP the owner being served is about to become lastOwner, so the pick already sees it
    assign pick_last = (state_q == RESP) ? owner_q : last_q;
    assign take      = any_req && (state_q == IDLE || state_q == RESP);

    rr_pick2 u_pick (
        .req0 (cpuReq),
        .req1 (dbgReq),
        .last (pick_last),
        .pick (pick),
        .any  (any_req)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        case (state_q)
            IDLE:   state_d = any_req ? ACCESS : IDLE;
            ACCESS: state_d = RESP;
            RESP: begin
                last_d  = owner_q;
                state_d = any_req ? ACCESS : IDLE;
                if (!we_q) begin
                    if (owner_q == OWN_DBG) begin
                        dbg_rdata_d = memRData;
                    end else begin
                        cpu_rdata_d = memRData;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            owner_d = pick;
            if (pick == OWN_DBG) begin
                we_d    = dbgWe;
                addr_d  = dbgAddr;
                wdata_d = dbgWData;
            end else begin
                we_d    = cpuWe;
                addr_d  = cpuAddr;
                wdata_d = cpuWData;
            end
        end
    end

    always_ff @(posedge sysCLK) begin
        if (pRST) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_DBG;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign cpuGnt   = (state_q == ACCESS) && (owner_q == OWN_CPU);
    assign dbgGnt   = (state_q == ACCESS) && (owner_q == OWN_DBG);
    assign cpuValid = (state_q == RESP) && (owner_q == OWN_CPU);
    assign dbgValid = (state_q == RESP) && (owner_q == OWN_DBG);
    assign memRW    = (state_q == ACCESS) && we_q;
    assign memAddr  = addr_q;
    assign memWData = wdata_q;

    // Read data bypasses the holding register in RESP so it is usable alongside Valid
    assign cpuRData = (cpuValid && !we_q) ? memRData : cpu_rdata_q;
    assign dbgRData = (dbgValid && !we_q) ? memRData : dbg_rdata_q;
    assign cpuStall = cpuReq && !cpuValid && !pRST;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (vectors, corner sequences, random traffic)
module tb_dmem_arbiter;

`ifdef DMEM_ARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        sysCLK, pRST;
    logic        cpuReq, cpuWe, cpuGnt, cpuValid, cpuStall;
    logic [15:0] cpuAddr;
    logic [31:0] cpuWData, cpuRData;
    logic        dbgReq, dbgWe, dbgGnt, dbgValid;
    logic [15:0] dbgAddr;
    logic [31:0] dbgWData, dbgRData;
    logic [15:0] memAddr;
    logic [31:0] memWData, memRData;
    logic        memRW;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.addrW(16), .dataW(32)) dut (
        .sysCLK(sysCLK), .pRST(pRST),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
        .cpuGnt(cpuGnt), .cpuRData(cpuRData), .cpuValid(cpuValid), .cpuStall(cpuStall),
        .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWData(dbgWData),
        .dbgGnt(dbgGnt), .dbgRData(dbgRData), .dbgValid(dbgValid),
        .memAddr(memAddr), .memWData(memWData), .memRW(memRW), .memRData(memRData)
    );

    initial sysCLK = 1'b0;
    always #5 sysCLK = ~sysCLK;

    // Registered single-port memory, read-before-write
    logic [31:0] mem [0:65535];
    always @(posedge sysCLK) begin
        if (memRW) mem[memAddr] <= memWData;
        memRData <= mem[memAddr];
    end

    // Reference contents as seen through completed transactions
    logic [31:0] ref_mem [logic [15:0]];

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sysCLK);
        @(negedge sysCLK);
    endtask

    task automatic do_reset(input logic reqs);
        pRST   = 1'b1;
        cpuReq = reqs;
        dbgReq = reqs;
        step();
        step();
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    // Random-phase state
    logic        rq      [2];
    logic        granted [2];
    logic        tx_we   [2];
    logic [15:0] tx_addr [2];
    logic [31:0] tx_wd   [2];
    int          waitc   [2];
    int          last_served, prev_who, exp_who, limit;
    bit          abort, seen;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        cpuWe = 1'b0; cpuAddr = 16'h0001; cpuWData = 32'h0;
        dbgWe = 1'b0; dbgAddr = 16'h0002; dbgWData = 32'h0;

        // Reset with both requests held
        do_reset(1'b1);
        chk1("rst_cpuGnt", cpuGnt, 1'b0);
        chk1("rst_dbgGnt", dbgGnt, 1'b0);
        chk1("rst_cpuValid", cpuValid, 1'b0);
        chk1("rst_dbgValid", dbgValid, 1'b0);
        chk1("rst_memRW", memRW, 1'b0);
        chk1("rst_cpuStall", cpuStall, 1'b0);
        chk32("rst_memAddr", {16'h0, memAddr}, 32'h0);
        chk32("rst_memWData", memWData, 32'h0);
        chk32("rst_cpuRData", cpuRData, 32'h0);
        chk32("rst_dbgRData", dbgRData, 32'h0);
        pRST = 1'b0;
        step();
        chk1("first_pick_cpuGnt", cpuGnt, 1'b1);
        chk1("first_pick_dbgGnt", dbgGnt, 1'b0);
        chk32("first_pick_memAddr", {16'h0, memAddr}, 32'h0000_0001);
        do_reset(1'b0);
        pRST = 1'b0;

        // CPU single transactions from IDLE; exp_rdata for writes is the held previous read
        vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 32'h0000_0000};
        vecs[1] = '{1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 16'h0020, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 16'hFFFF, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 16'h0020, 32'h0,        32'h12345678};
        vecs[5] = '{1'b0, 16'hFFFF, 32'h0,        32'hA5A5A5A5};
        vecs[6] = '{1'b1, 16'h0010, 32'hCAFEF00D, 32'hA5A5A5A5};
        vecs[7] = '{1'b0, 16'h0010, 32'h0,        32'hCAFEF00D};
        for (int v = 0; v < 8; v++) begin
            cpuReq = 1'b1; cpuWe = vecs[v].we; cpuAddr = vecs[v].addr; cpuWData = vecs[v].wdata;
            #1;
            chk1("vec_c1_stall", cpuStall, 1'b1);
            chk1("vec_c1_gnt", cpuGnt, 1'b0);
            step();
            chk1("vec_c2_gnt", cpuGnt, 1'b1);
            chk1("vec_c2_memRW", memRW, vecs[v].we);
            chk1("vec_c2_stall", cpuStall, 1'b1);
            chk1("vec_c2_valid", cpuValid, 1'b0);
            chk32("vec_c2_memAddr", {16'h0, memAddr}, {16'h0, vecs[v].addr});
            if (vecs[v].we) chk32("vec_c2_memWData", memWData, vecs[v].wdata);
            // Inputs changed after the pick must be ignored
            cpuAddr = vecs[v].addr ^ 16'h0020; cpuWData = ~vecs[v].wdata; cpuWe = ~vecs[v].we;
            step();
            chk1("vec_c3_valid", cpuValid, 1'b1);
            chk1("vec_c3_memRW", memRW, 1'b0);
            chk1("vec_c3_stall", cpuStall, 1'b0);
            chk1("vec_c3_dbgValid", dbgValid, 1'b0);
            chk32("vec_c3_memAddr", {16'h0, memAddr}, {16'h0, vecs[v].addr});
            chk32("vec_c3_rdata", cpuRData, vecs[v].exp_rdata);
            if (vecs[v].we) ref_mem[vecs[v].addr] = vecs[v].wdata;
            cpuReq = 1'b0;
            step();
            chk1("vec_c4_valid", cpuValid, 1'b0);
            chk1("vec_c4_gnt", cpuGnt, 1'b0);
            chk32("vec_c4_rdata_held", cpuRData, vecs[v].we ? vecs[v].exp_rdata : ref_rd(vecs[v].addr));
        end

        // Contention: CPU reads 0x0010, debug writes 0x55 to 0x0020
        do_reset(1'b0);
        pRST = 1'b0;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h0010;
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 16'h0020; dbgWData = 32'h0000_0055;
        for (int i = 1; i <= 8; i++) begin
            int own;
            step();
            own = PRIO ? 0 : ((i - 1) / 2) % 2;
            chk1("cont_cpuGnt", cpuGnt, (i % 2 == 1) && own == 0);
            chk1("cont_dbgGnt", dbgGnt, (i % 2 == 1) && own == 1);
            chk1("cont_cpuValid", cpuValid, (i % 2 == 0) && own == 0);
            chk1("cont_dbgValid", dbgValid, (i % 2 == 0) && own == 1);
            if (cpuValid) chk32("cont_cpuRData", cpuRData, 32'hCAFEF00D);
        end
        cpuReq = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step();
            if (dbgValid) seen = 1'b1;
        end
        chk1("cont_dbg_served_after_cpu_drop", seen, 1'b1);
        ref_mem[16'h0020] = 32'h0000_0055;
        dbgReq = 1'b0;
        step();

        // Reset during a debug write's ACCESS
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 16'h0040; dbgWData = 32'h0000_0077;
        step();
        chk1("midrst_dbgGnt", dbgGnt, 1'b1);
        chk1("midrst_memRW_before", memRW, 1'b1);
        pRST = 1'b1;
        step();
        chk1("midrst_dbgValid", dbgValid, 1'b0);
        chk1("midrst_memRW_after", memRW, 1'b0);
        chk1("midrst_dbgGnt_after", dbgGnt, 1'b0);
        pRST = 1'b0; cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h0003; dbgWe = 1'b0;
        step();
        chk1("midrst_next_cpuGnt", cpuGnt, 1'b1);
        chk1("midrst_next_dbgGnt", dbgGnt, 1'b0);
        do_reset(1'b0);
        pRST = 1'b0;

        // Random traffic against a transaction-level model
        last_served = 1; prev_who = -1; abort = 1'b0;
        limit = PRIO ? 100 : 8;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; granted[i] = 1'b0; waitc[i] = 0;
            tx_we[i] = 1'b0; tx_addr[i] = 16'h0; tx_wd[i] = 32'h0;
        end
        for (int cyc = 0; cyc < 3000 && !abort; cyc++) begin
            step();
            exp_who = -1;
            if (prev_who < 0 && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) exp_who = PRIO ? 0 : (last_served == 0 ? 1 : 0);
                else                exp_who = rq[0] ? 0 : 1;
            end
            chk1("rnd_cpuGnt", cpuGnt, exp_who == 0);
            chk1("rnd_dbgGnt", dbgGnt, exp_who == 1);
            chk1("rnd_cpuValid", cpuValid, prev_who == 0);
            chk1("rnd_dbgValid", dbgValid, prev_who == 1);
            chk1("rnd_cpuStall", cpuStall, rq[0] && !cpuValid);
            if (exp_who >= 0) begin
                chk32("rnd_memAddr", {16'h0, memAddr}, {16'h0, tx_addr[exp_who]});
                chk1("rnd_memRW", memRW, tx_we[exp_who]);
                if (tx_we[exp_who]) chk32("rnd_memWData", memWData, tx_wd[exp_who]);
                granted[exp_who] = 1'b1;
            end
            if (prev_who >= 0) begin
                if (tx_we[prev_who]) ref_mem[tx_addr[prev_who]] = tx_wd[prev_who];
                else chk32("rnd_rdata", prev_who == 0 ? cpuRData : dbgRData, ref_rd(tx_addr[prev_who]));
                last_served = prev_who;
                rq[prev_who] = 1'b0;
                granted[prev_who] = 1'b0;
                waitc[prev_who] = 0;
            end
            prev_who = exp_who;
            for (int r = 0; r < 2; r++) begin
                if (rq[r]) begin
                    waitc[r]++;
                    if (waitc[r] > limit) begin
                        checks++; errors++; abort = 1'b1;
                        $display("FAIL rnd_timeout: requester %0d waited %0d cycles, limit %0d", r, waitc[r], limit);
                    end
                end else if ($urandom_range(0, 9) < 4) begin
                    rq[r] = 1'b1; granted[r] = 1'b0; waitc[r] = 0;
                    tx_we[r] = 1'($urandom_range(0, 1));
                    tx_addr[r] = 16'($urandom_range(0, 15));
                    tx_wd[r] = $urandom;
                end
            end
            cpuReq = rq[0]; dbgReq = rq[1];
            if (granted[0]) begin
                cpuWe = 1'($urandom_range(0, 1)); cpuAddr = 16'($urandom); cpuWData = $urandom;
            end else begin
                cpuWe = tx_we[0]; cpuAddr = tx_addr[0]; cpuWData = tx_wd[0];
            end
            if (granted[1]) begin
                dbgWe = 1'($urandom_range(0, 1)); dbgAddr = 16'($urandom); dbgWData = $urandom;
            end else begin
                dbgWe = tx_we[1]; dbgAddr = tx_addr[1]; dbgWData = tx_wd[1];
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
